// File: rtl/detector_nota.sv
// detector_nota: classifies the half-period of a buzzer square wave into a note and octave,
// reporting it once the same class is seen CONFIRMAR consecutive times.
module detector_nota #(
  parameter int          CONFIRMAR  = 4,
  parameter int          TOLERANCIA = 512,
  parameter int          ESCALA     = 1,
  parameter logic [19:0] SATURACION = 20'hFFFFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entrada,
  output logic [2:0] nota,
  output logic       octava,
  output logic       valida,
  output logic       nueva
);
  typedef enum logic [1:0] {BUSCAR, CONFIRMANDO, BLOQUEADO} estado_t;
  localparam int CW = $clog2(CONFIRMAR + 1);
  localparam logic [CW-1:0] CONF = CW'(CONFIRMAR);
  localparam int NOM_A [5] = '{47779, 42567, 37923, 35794, 50620};
  localparam int NOM_B [5] = '{95557, 85132, 75844, 71588, 101239};
  estado_t       estado;
  logic [2:0]    sinc;
  logic [19:0]   cnt;
  logic [3:0]    cand, clase;
  logic [CW-1:0] coinc, coinc_sig;
  logic          pulso;
  // Returns {octava, nota}; a measurement outside every window is "none" (all zero)
  function automatic logic [3:0] clasificar(input logic [19:0] m);
    int d;
    clasificar = '0;
    for (int i = 0; i < 5; i++) begin
      d = int'(m) - NOM_A[i] / ESCALA;
      if ((d < 0 ? -d : d) <= TOLERANCIA) clasificar = {1'b0, 3'(i + 1)};
      d = int'(m) - NOM_B[i] / ESCALA;
      if ((d < 0 ? -d : d) <= 2 * TOLERANCIA) clasificar = {1'b1, 3'(i + 1)};
    end
  endfunction
  assign pulso     = sinc[1] ^ sinc[2];
  assign clase     = clasificar(cnt);
  assign coinc_sig = (clase == cand) ? ((coinc == CONF) ? coinc : coinc + 1'b1) : CW'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sinc   <= '0;
      cnt    <= '0;
      estado <= BUSCAR;
      cand   <= '0;
      coinc  <= '0;
      nota   <= '0;
      octava <= 1'b0;
      valida <= 1'b0;
      nueva  <= 1'b0;
    end else begin
      sinc  <= {sinc[1:0], entrada};
      nueva <= 1'b0;
      if (pulso) begin
        cnt <= 20'd1;
        if (estado == BUSCAR) begin
          estado <= CONFIRMANDO;
          cand   <= '0;
          coinc  <= '0;
        end else begin
          cand  <= clase;
          coinc <= coinc_sig;
          if (coinc_sig == CONF && clase != {octava, nota}) begin
            {octava, nota} <= clase;
            valida         <= clase[2:0] != 3'd0;
            nueva          <= 1'b1;
            estado         <= BLOQUEADO;
          end
        end
      end else if (cnt == SATURACION) begin
        estado <= BUSCAR;
        cand   <= '0;
        coinc  <= '0;
        nota   <= '0;
        octava <= 1'b0;
        valida <= 1'b0;
        nueva  <= nota != 3'd0;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end
endmodule

// File: tb/tb_detector_nota.sv
// tb_detector_nota: scoreboard bench; nominal half-periods scaled by 64 to keep runs short.
module tb_detector_nota;
  localparam int ESC = 64;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       entrada = 1'b0;
  logic [2:0] nota;
  logic       octava, valida, nueva;
  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] q [$];
  // scaled half-periods: do 746, re 665, mi 592, fa 559, si 790; low do 1493, si 1581
  detector_nota #(.CONFIRMAR(4), .TOLERANCIA(8), .ESCALA(ESC), .SATURACION(20'd4095)) dut (
    .clk(clk), .rst_n(rst_n), .entrada(entrada),
    .nota(nota), .octava(octava), .valida(valida), .nueva(nueva)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst_n) begin
      n_vec++;
      if (valida !== (nota != 3'd0)) begin
        n_err++;
        $display("FAIL valida_consistency: valida=%b nota=%0d", valida, nota);
      end
      if (nueva === 1'b1) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_nueva at %0t: nota=%0d octava=%b", $time, nota, octava);
        end else begin
          logic [3:0] e;
          e = q.pop_front();
          if ({octava, nota, valida} !== {e, e[2:0] != 3'd0}) begin
            n_err++;
            $display("FAIL nueva_value: got nota=%0d octava=%b valida=%b expected nota=%0d octava=%b",
                     nota, octava, valida, e[2:0], e[3]);
          end
        end
      end
    end
  end
  task automatic tono(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (p) @(negedge clk);
      entrada = ~entrada;
    end
  endtask
  task automatic settle(input string name, input logic [3:0] exp);
    repeat (6) @(negedge clk);
    n_vec++;
    if (q.size() != 0 || {octava, nota} !== exp) begin
      n_err++;
      $display("FAIL %s: pending=%0d nota=%0d octava=%b expected nota=%0d octava=%b",
               name, q.size(), nota, octava, exp[2:0], exp[3]);
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({nota, octava, valida, nueva} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_state: got %b expected 000000", {nota, octava, valida, nueva});
    end
    rst_n = 1'b1;
    settle("reset_release", 4'h0);
  endtask
  task automatic test_lock_mi();
    tono(592, 4);
    settle("mi_before_confirm", 4'h0);
    q.push_back({1'b0, 3'd3});
    repeat (592 - 6) @(negedge clk);
    entrada = ~entrada;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_vec++;
      if (nueva !== (k == 3)) begin
        n_err++;
        $display("FAIL mi_latency: cycle %0d nueva=%b expected %b", k, nueva, k == 3);
      end
    end
    tono(592, 6);
    settle("mi_hold", {1'b0, 3'd3});
  endtask
  task automatic test_switch();
    q.push_back({1'b1, 3'd5});
    tono(1581, 4);
    settle("si_low", {1'b1, 3'd5});
    q.push_back({1'b0, 3'd1});
    tono(746, 4);
    settle("do_high", {1'b0, 3'd1});
  endtask
  task automatic test_glitch();
    tono(746, 1);
    tono(937, 1);
    tono(746, 3);
    settle("do_glitch", {1'b0, 3'd1});
    tono(746, 3);
    settle("do_glitch_after", {1'b0, 3'd1});
  endtask
  task automatic test_timeout();
    q.push_back({1'b0, 3'd4});
    tono(559, 4);
    settle("fa_lock", {1'b0, 3'd4});
    q.push_back(4'h0);
    repeat (4100) @(negedge clk);
    settle("fa_timeout", 4'h0);
  endtask
  task automatic test_tolerance();
    q.push_back({1'b0, 3'd1});
    tono(754, 5);
    settle("do_plus_tol", {1'b0, 3'd1});
    q.push_back(4'h0);
    repeat (4100) @(negedge clk);
    settle("do_timeout", 4'h0);
    tono(755, 8);
    settle("do_plus_tol_plus1", 4'h0);
  endtask
  task automatic test_reset_mid();
    q.push_back({1'b0, 3'd2});
    tono(665, 4);
    settle("re_lock", {1'b0, 3'd2});
    if (entrada) tono(665, 1);
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({nota, octava, valida, nueva} !== 6'b0) begin
      n_err++;
      $display("FAIL async_reset: got %b expected 000000", {nota, octava, valida, nueva});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tono(665, 4);
    settle("re_after_reset_4", 4'h0);
    q.push_back({1'b0, 3'd2});
    tono(665, 1);
    settle("re_after_reset_5", {1'b0, 3'd2});
  endtask
  initial begin
    test_reset();
    test_lock_mi();
    test_switch();
    test_glitch();
    test_timeout();
    test_tolerance();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
